// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, constants and the round-robin search helper for the
// FIFO write-port arbiter.
package fifo_arb_pkg;

    // Width of the per-grant beat counter; MAX_BURST is capped at 255 so it never wraps.
    localparam int BEAT_CNT_W = 8;
    // Largest supported requester count; the search helper works at this width.
    localparam int MAX_NREQ   = 16;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Result of a round-robin search.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_res_t;

    // Wrap-around search starting one past ptr; the first set valid bit wins.
    // ptr must already be below nreq, so one conditional subtract keeps the
    // candidate index in range and a non-power-of-2 nreq never over-indexes.
    function automatic rr_res_t rr_next(input logic [MAX_NREQ-1:0] valid,
                                        input logic [3:0]          ptr,
                                        input int unsigned         nreq);
        rr_res_t    r;
        logic [4:0] cand;
        r = '{found: 1'b0, idx: 4'd0};
        for (int k = 1; k <= MAX_NREQ; k++) begin
            if (k <= int'(nreq)) begin
                cand = 5'(ptr) + 5'(k);
                if (cand >= 5'(nreq)) cand = cand - 5'(nreq);
                if (!r.found && valid[cand[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = cand[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer streams plus FIFO write side seen by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_write;
    logic [IDW+WIDTH-1:0]  fifo_wdata;
    logic                  busy;
    logic [IDW-1:0]        owner;

    // Arbiter side: consumes producer streams, drives the FIFO write port.
    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write, fifo_wdata, busy, owner
    );

    // Environment side: producers and the FIFO.
    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write, fifo_wdata, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search over NREQ valid bits from a start pointer.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic            o_found,
    output logic [IDW-1:0]  o_idx
);
    rr_res_t w_res;

    // Widen to the helper's fixed width and narrow the winner back to IDW bits.
    always_comb begin
        w_res   = rr_next(MAX_NREQ'(i_valid), 4'(i_ptr), NREQ);
        o_found = w_res.found;
        o_idx   = IDW'(w_res.idx);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// One ARB cycle picks an owner, then BURST forwards up to MAX_BURST beats
// tagged with the owner id. A full FIFO stalls the burst but never rotates it.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.master  bus
);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);
    localparam logic [IDW-1:0]        PTR_RST   = IDW'(NREQ - 1);

    arb_state_e              r_state;
    logic [IDW-1:0]          r_rr_ptr;
    logic [IDW-1:0]          r_owner;
    logic [BEAT_CNT_W-1:0]   r_beat_cnt;

    arb_state_e              w_state_nxt;
    logic [IDW-1:0]          w_rr_ptr_nxt;
    logic [IDW-1:0]          w_owner_nxt;
    logic [BEAT_CNT_W-1:0]   w_beat_cnt_nxt;

    logic                    w_found;
    logic [IDW-1:0]          w_win;
    logic [NREQ-1:0][WIDTH-1:0] w_req_data;
    logic                    w_own_valid;
    logic                    w_beat;

    assign w_req_data  = bus.req_data;
    assign w_own_valid = bus.req_valid[r_owner];
    // A beat moves only while the owner has data and the FIFO has room.
    assign w_beat      = w_own_valid & ~bus.fifo_full;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .i_valid (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    // State register and arbitration bookkeeping, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB;
            r_rr_ptr   <= PTR_RST;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Next state: grant in ARB, count beats and release the grant in BURST.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ARB: begin
                if (w_found) begin
                    w_owner_nxt    = w_win;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = BURST;
                end
            end
            BURST: begin
                if (!w_own_valid) begin
                    // Owner went idle: drop the grant so it loses priority.
                    w_rr_ptr_nxt = r_owner;
                    w_state_nxt  = ARB;
                end else if (w_beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_rr_ptr_nxt = r_owner;
                        w_state_nxt  = ARB;
                    end
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // Outputs: decoded from the registered owner; fifo_full only gates, never feeds valid.
    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_write = 1'b0;
        bus.fifo_wdata = {r_owner, w_req_data[r_owner]};
        bus.busy       = (r_state == BURST);
        bus.owner      = r_owner;
        if (r_state == BURST) begin
            bus.req_ready[r_owner] = ~bus.fifo_full;
            bus.fifo_write         = w_beat;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-requester instance and a
// 3-requester instance, checked cycle by cycle against hand-derived tables.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(4), .IDW(2), .WIDTH(8)) a_if ();
    fifo_wr_arbiter_if #(.NREQ(3), .IDW(2), .WIDTH(8)) b_if ();

    fifo_wr_arbiter #(.NREQ(4), .IDW(2), .WIDTH(8), .MAX_BURST(4)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.master)
    );

    fifo_wr_arbiter #(.NREQ(3), .IDW(2), .WIDTH(8), .MAX_BURST(4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    // One cycle of instance A: write strobe, busy, owner, ready vector, tagged data.
    task automatic exp_a(input string tag, input bit wr, input int own, input bit bsy,
                         input logic [3:0] rdy);
        logic [9:0] e;
        e = {2'(own), 8'(8'hA0 + own)};
        chk({tag, ".wr"},  32'(a_if.fifo_write), 32'(wr));
        chk({tag, ".bsy"}, 32'(a_if.busy),       32'(bsy));
        chk({tag, ".own"}, 32'(a_if.owner),      32'(own));
        chk({tag, ".rdy"}, 32'(a_if.req_ready),  32'(rdy));
        if (wr) chk({tag, ".wd"}, 32'(a_if.fifo_wdata), 32'(e));
    endtask

    task automatic exp_b(input string tag, input bit wr, input int own, input bit bsy,
                         input logic [2:0] rdy);
        logic [9:0] e;
        e = {2'(own), 8'(8'hB0 + own)};
        chk({tag, ".wr"},  32'(b_if.fifo_write), 32'(wr));
        chk({tag, ".bsy"}, 32'(b_if.busy),       32'(bsy));
        chk({tag, ".own"}, 32'(b_if.owner),      32'(own));
        chk({tag, ".rdy"}, 32'(b_if.req_ready),  32'(rdy));
        if (wr) chk({tag, ".wd"}, 32'(b_if.fifo_wdata), 32'(e));
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    initial begin
        int c;
        reset          = 1'b1;
        a_if.req_valid = '0;
        a_if.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        a_if.fifo_full = 1'b0;
        b_if.req_valid = '0;
        b_if.req_data  = {8'hB2, 8'hB1, 8'hB0};
        b_if.fifo_full = 1'b0;

        // Reset state.
        @(negedge clk);
        exp_a("rst", 0, 0, 0, 4'b0000);
        exp_b("rstb", 0, 0, 0, 3'b000);

        // Single requester 2: 4 beats, 1-cycle gap, re-granted.
        reset = 1'b0;
        a_if.req_valid = 4'b0100;
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            if ((c - 1) % 5 != 4) exp_a($sformatf("s1.c%0d", c), 1, 2, 1, 4'b0100);
            else                  exp_a($sformatf("s1.c%0d", c), 0, 2, 0, 4'b0000);
        end

        // All requesters valid from reset: owners 0,1,2,3,0 with 20-cycle rounds.
        reset = 1'b1;
        a_if.req_valid = 4'b1111;
        @(negedge clk);
        exp_a("rst2", 0, 0, 0, 4'b0000);
        reset = 1'b0;
        for (c = 1; c <= 25; c++) begin
            int own;
            @(negedge clk);
            own = ((c - 1) / 5) % 4;
            if ((c - 1) % 5 != 4) exp_a($sformatf("s2.c%0d", c), 1, own, 1, 4'(1 << own));
            else                  exp_a($sformatf("s2.c%0d", c), 0, own, 0, 4'b0000);
        end

        // Owner 1 drops valid after 2 beats; grant moves on to 2 with a fresh count.
        for (c = 26; c <= 27; c++) begin
            @(negedge clk);
            exp_a($sformatf("s3.c%0d", c), 1, 1, 1, 4'b0010);
        end
        a_if.req_valid = 4'b1101;
        @(negedge clk);
        exp_a("s3.c28", 0, 1, 0, 4'b0000);
        for (c = 29; c <= 32; c++) begin
            @(negedge clk);
            exp_a($sformatf("s3.c%0d", c), 1, 2, 1, 4'b0100);
        end
        @(negedge clk);
        exp_a("s3.c33", 0, 2, 0, 4'b0000);

        // Owner 3: one beat, 5-cycle full stall, remaining 3 beats, no rotation.
        @(negedge clk);
        exp_a("s4.c34", 1, 3, 1, 4'b1000);
        a_if.fifo_full = 1'b1;
        for (c = 35; c <= 39; c++) begin
            @(negedge clk);
            exp_a($sformatf("s4.c%0d", c), 0, 3, 1, 4'b0000);
        end
        a_if.fifo_full = 1'b0;
        for (c = 40; c <= 42; c++) begin
            @(negedge clk);
            exp_a($sformatf("s4.c%0d", c), 1, 3, 1, 4'b1000);
        end
        @(negedge clk);
        exp_a("s4.c43", 0, 3, 0, 4'b0000);

        // Reset during beat 2 of owner 0; the next grant is a full 4-beat burst to 0.
        for (c = 44; c <= 45; c++) begin
            @(negedge clk);
            exp_a($sformatf("s5.c%0d", c), 1, 0, 1, 4'b0001);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_a("s5.c46", 0, 0, 0, 4'b0000);
        reset = 1'b0;
        for (c = 47; c <= 50; c++) begin
            @(negedge clk);
            exp_a($sformatf("s5.c%0d", c), 1, 0, 1, 4'b0001);
        end
        @(negedge clk);
        exp_a("s5.c51", 0, 0, 0, 4'b0000);

        // NREQ=3 with requesters 0 and 2: grants alternate 0,2,0,2 across the wrap.
        reset = 1'b1;
        a_if.req_valid = '0;
        b_if.req_valid = 3'b101;
        @(negedge clk);
        exp_b("s6.rst", 0, 0, 0, 3'b000);
        reset = 1'b0;
        for (c = 1; c <= 20; c++) begin
            int own;
            @(negedge clk);
            own = (((c - 1) / 5) % 2 == 0) ? 0 : 2;
            if ((c - 1) % 5 != 4) exp_b($sformatf("s6.c%0d", c), 1, own, 1, 3'(1 << own));
            else                  exp_b($sformatf("s6.c%0d", c), 0, own, 0, 3'b000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
